// File: rtl/acc_pkg.sv
// Shared encodings for the AH/AL accumulator pair and its multiply/divide sequencer.
package acc_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/acc_shreg.sv
// One accumulator half: hold / shift right / shift left / parallel load register.
module acc_shreg
  import acc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [1:0]   c,
  input  logic         fill_msb,
  input  logic         fill_lsb,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out
);

  logic [W-1:0] r_q, r_d;

  always_comb begin
    r_d = r_q;
    case (mode_e'(c))
      MODE_HOLD: r_d = r_q;
      MODE_SHR:  r_d = {fill_msb, r_q[W-1:1]};
      MODE_SHL:  r_d = {r_q[W-2:0], fill_lsb};
      MODE_LOAD: r_d = data_in;
      default:   r_d = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) r_q <= '0;
    else     r_q <= r_d;
  end

  assign data_out = r_q;

endmodule

// File: rtl/acc_seq.sv
// AH/AL accumulator pair with manual shift/load control and a shift-add multiply sequencer.
// Define ACC_DIV_EN to add a restoring divider selected by op=1.
module acc_seq
  import acc_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ah_reset,
  input  logic         ah_inen,
  input  logic [W-1:0] ah_in,
  input  logic [W-1:0] aludata,
  input  logic [W-1:0] al_in,
  input  logic         carry_in,
  input  logic [1:0]   hs,
  input  logic [1:0]   ls,
  input  logic         start,
  input  logic [W-1:0] opnd,
  input  logic         op,
  output logic         busy,
  output logic         done,
  output logic         dz,
  output logic         carry_out,
  output logic [W-1:0] ah_out,
  output logic [W-1:0] al_out
);

  localparam int CW = $clog2(W);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   opnd_q, opnd_d;
  logic           c_q, c_d;
  logic           done_q, done_d;

  logic [1:0]     ah_c, al_c;
  logic [W-1:0]   ah_din, al_din;
  logic [W-1:0]   ah, al;
  logic [W-1:0]   addend;
  logic [W:0]     mul_sum;

  assign addend  = al[0] ? opnd_q : {W{1'b0}};
  assign mul_sum = {1'b0, ah} + {1'b0, addend};

`ifdef ACC_DIV_EN
  logic           op_q, op_d;
  logic           dz_q, dz_d;
  logic [W:0]     rem;
  logic [W+1:0]   diff;
  assign rem  = {ah, al[W-1]};
  assign diff = {1'b0, rem} - {2'b00, opnd_q};
`else
  logic unused_op;
  assign unused_op = op;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    c_d     = c_q;
    done_d  = 1'b0;
    ah_c    = hs;
    al_c    = ls;
    ah_din  = ah_inen ? ah_in : aludata;
    al_din  = al_in;
`ifdef ACC_DIV_EN
    op_d    = op_q;
    dz_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // AL keeps the multiplier/dividend; AH becomes the running partial.
          opnd_d  = opnd;
          ah_c    = MODE_LOAD;
          ah_din  = '0;
          al_c    = MODE_HOLD;
          c_d     = 1'b0;
          cnt_d   = CW'(W - 1);
          state_d = ST_RUN;
`ifdef ACC_DIV_EN
          op_d    = op;
`endif
        end else if (ah_reset) begin
          ah_c   = MODE_LOAD;
          ah_din = '0;
        end
      end
      ST_RUN: begin
        ah_c   = MODE_LOAD;
        al_c   = MODE_LOAD;
        c_d    = 1'b0;
        ah_din = mul_sum[W:1];
        al_din = {mul_sum[0], al[W-1:1]};
`ifdef ACC_DIV_EN
        if (op_q == OP_DIV) begin
          // Borrow shows in the top bit of the widened trial difference.
          if (!diff[W+1]) begin
            ah_din = diff[W-1:0];
            al_din = {al[W-2:0], 1'b1};
          end else begin
            ah_din = rem[W-1:0];
            al_din = {al[W-2:0], 1'b0};
          end
        end
`endif
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
`ifdef ACC_DIV_EN
          dz_d    = (op_q == OP_DIV) && (opnd_q == '0);
`endif
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef ACC_DIV_EN
      op_q    <= OP_MUL;
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      c_q     <= c_d;
      done_q  <= done_d;
`ifdef ACC_DIV_EN
      op_q    <= op_d;
      dz_q    <= dz_d;
`endif
    end
  end

  acc_shreg #(.W(W)) u_ah (
    .clk      (clk),
    .clr      (clr),
    .c        (ah_c),
    .fill_msb (carry_in),
    .fill_lsb (al[W-1]),
    .data_in  (ah_din),
    .data_out (ah)
  );

  acc_shreg #(.W(W)) u_al (
    .clk      (clk),
    .clr      (clr),
    .c        (al_c),
    .fill_msb (ah[0]),
    .fill_lsb (carry_in),
    .data_in  (al_din),
    .data_out (al)
  );

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign carry_out = c_q;
  assign ah_out    = ah;
  assign al_out    = al;
`ifdef ACC_DIV_EN
  assign dz        = dz_q;
`else
  assign dz        = 1'b0;
`endif

endmodule

// File: tb/tb_acc_seq.sv
// Directed bench for acc_seq (W=4) with an arithmetic reference model checked every cycle.
module tb_acc_seq;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic         ah_reset = 1'b0, ah_inen = 1'b0, carry_in = 1'b0, start = 1'b0, op = 1'b0;
  logic [W-1:0] ah_in = '0, aludata = '0, al_in = '0, opnd = '0;
  logic [1:0]   hs = 2'b00, ls = 2'b00;
  logic         busy, done, dz, carry_out;
  logic [W-1:0] ah_out, al_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  acc_seq #(.W(W)) dut (
    .clk(clk), .clr(clr), .ah_reset(ah_reset), .ah_inen(ah_inen), .ah_in(ah_in),
    .aludata(aludata), .al_in(al_in), .carry_in(carry_in), .hs(hs), .ls(ls),
    .start(start), .opnd(opnd), .op(op), .busy(busy), .done(done), .dz(dz),
    .carry_out(carry_out), .ah_out(ah_out), .al_out(al_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on whole register values.
  int m_ah = 0, m_al = 0, m_cnt = 0, r_ah = 0, r_al = 0;
  bit m_done = 0, m_dz = 0, r_dz = 0;

  always @(posedge clk) begin
    int na, nl, a, b;
    if (clr) begin
      m_ah = 0; m_al = 0; m_cnt = 0; m_done = 0; m_dz = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      m_done = 0;
      if (m_cnt == 0) begin
        m_ah = r_ah; m_al = r_al; m_done = 1; m_dz = r_dz;
      end
    end else begin
      m_done = 0; m_dz = 0;
      if (start) begin
        a = m_al; b = int'(opnd);
        r_dz = 0;
`ifdef ACC_DIV_EN
        if (op) begin
          if (b == 0) begin r_al = 15; r_ah = a; r_dz = 1; end
          else begin r_al = a / b; r_ah = a % b; end
        end else begin
          r_ah = (a * b) / 16; r_al = (a * b) % 16;
        end
`else
        r_ah = (a * b) / 16; r_al = (a * b) % 16;
`endif
        m_cnt = W;
        m_ah = 0;
      end else begin
        na = m_ah; nl = m_al;
        case (hs)
          2'b01: na = m_ah / 2 + int'(carry_in) * 8;
          2'b10: na = (m_ah * 2 + m_al / 8) % 16;
          2'b11: na = ah_inen ? int'(ah_in) : int'(aludata);
          default: na = m_ah;
        endcase
        case (ls)
          2'b01: nl = m_al / 2 + (m_ah % 2) * 8;
          2'b10: nl = (m_al * 2 + int'(carry_in)) % 16;
          2'b11: nl = int'(al_in);
          default: nl = m_al;
        endcase
        if (ah_reset) na = 0;
        m_ah = na; m_al = nl;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_cnt > 0});
      chk("model_done", {31'd0, done}, {31'd0, m_done});
      chk("model_dz",   {31'd0, dz},   {31'd0, m_dz});
      chk("model_c",    {31'd0, carry_out}, 32'd0);
      if (m_cnt == 0) begin
        chk("model_ah", {28'd0, ah_out}, m_ah);
        chk("model_al", {28'd0, al_out}, m_al);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] l);
    hs = 2'b11; ls = 2'b11; ah_inen = 1'b1; ah_in = a; al_in = l;
    cyc();
    hs = 2'b00; ls = 2'b00;
  endtask

  task automatic launch(input logic [W-1:0] o, input logic opsel);
    start = 1'b1; opnd = o; op = opsel;
    cyc();
    start = 1'b0; op = 1'b0;
  endtask

  task automatic wait_done(output int bc);
    int k;
    bc = 0; k = 0;
    while (!done && k < 20) begin
      if (busy) bc++;
      cyc();
      k++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int bc;
    cyc(); cyc();
    clr = 1'b0;
    chk_en = 1;
    chk("rst_ah", {28'd0, ah_out}, 32'd0);
    chk("rst_al", {28'd0, al_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Manual shifts
    load(4'b1001, 4'b0110);
    hs = 2'b01; ls = 2'b01; carry_in = 1'b1; cyc();
    chk("shr_ah", {28'd0, ah_out}, 32'b1100);
    chk("shr_al", {28'd0, al_out}, 32'b1011);
    hs = 2'b10; ls = 2'b10; carry_in = 1'b0; cyc();
    chk("shl_ah", {28'd0, ah_out}, 32'b1001);
    chk("shl_al", {28'd0, al_out}, 32'b0110);
    hs = 2'b11; ls = 2'b00; ah_inen = 1'b0; aludata = 4'b0101; cyc();
    chk("alu_load", {28'd0, ah_out}, 32'b0101);
    ah_reset = 1'b1; hs = 2'b11; cyc();
    ah_reset = 1'b0; hs = 2'b00;
    chk("ah_reset", {28'd0, ah_out}, 32'd0);

    // 13 * 11 = 143
    load(4'b0000, 4'b1101);
    launch(4'b1011, 1'b0);
    wait_done(bc);
    chk("mul_busy_cycles", bc, 32'd4);
    chk("mul13x11_ah", {28'd0, ah_out}, 32'b1000);
    chk("mul13x11_al", {28'd0, al_out}, 32'b1111);

    // 15 * 15 = 225
    load(4'b0000, 4'b1111);
    launch(4'b1111, 1'b0);
    wait_done(bc);
    chk("mul15x15_ah", {28'd0, ah_out}, 32'b1110);
    chk("mul15x15_al", {28'd0, al_out}, 32'b0001);

    // Controls ignored while busy: 2 * 3 = 6
    load(4'b0000, 4'b0010);
    launch(4'b0011, 1'b0);
    start = 1'b1; opnd = 4'b1111; hs = 2'b11; ls = 2'b11; ah_inen = 1'b1;
    ah_in = 4'b1010; al_in = 4'b0101; ah_reset = 1'b1;
    cyc();
    start = 1'b0; hs = 2'b00; ls = 2'b00; ah_reset = 1'b0;
    wait_done(bc);
    chk("ign_ah", {28'd0, ah_out}, 32'd0);
    chk("ign_al", {28'd0, al_out}, 32'b0110);

    // Back-to-back start while done is high: 6 * 2 = 12
    launch(4'b0010, 1'b0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(bc);
    chk("b2b_al", {28'd0, al_out}, 32'b1100);

    // clr aborts a multiply after two RUN cycles
    load(4'b0000, 4'b1101);
    launch(4'b1011, 1'b0);
    cyc(); cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    chk("abort_ah", {28'd0, ah_out}, 32'd0);
    chk("abort_al", {28'd0, al_out}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      cyc();
    end

`ifdef ACC_DIV_EN
    load(4'b0000, 4'b1101);
    launch(4'b0011, 1'b1);
    wait_done(bc);
    chk("div_q", {28'd0, al_out}, 32'b0100);
    chk("div_r", {28'd0, ah_out}, 32'b0001);
    chk("div_dz", {31'd0, dz}, 32'd0);
    load(4'b0000, 4'b1101);
    launch(4'b0000, 1'b1);
    wait_done(bc);
    chk("dz_q", {28'd0, al_out}, 32'b1111);
    chk("dz_r", {28'd0, ah_out}, 32'b1101);
    chk("dz_flag", {31'd0, dz}, 32'd1);
`endif

    cyc(); cyc();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
